fpu_addsub_param: RTL and testbench
===================================

# fpu_addsub_param

Parametrised, handshaked floating-point adder/subtractor that succeeds the fixed 32-bit custom-format FPU adder. Each operand is sign | EXP_W exponent | MAN_W mantissa, with a hidden leading 1. The block adds operation select (add/sub), start/done/busy handshake, fixed latency, guard/round/sticky alignment with round-to-nearest-even, and saturating overflow / flush-to-zero underflow. It sits as a slave compute unit on the system clock next to other arithmetic blocks.

## Interface
Parameters:
- EXP_W, 6, exponent field width (unsigned field, no bias applied inside the block)
- MAN_W, 25, stored mantissa width (hidden 1 not stored)
- W, 1+EXP_W+MAN_W (32), word width, derived, not overridable

Ports:
- clock100KHz  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state on the edge where it is sampled high
- start  in  1  request pulse; sampled only in IDLE
- op_sub  in  1  0 = A+B, 1 = A−B (B sign inverted); latched with the operands
- op_A_in  in  W  operand A
- op_B_in  in  W  operand B
- busy  out  1  high from accept edge until result edge
- done  out  1  one-cycle pulse; result valid
- data_out  out  W  result; held until next done
- status_out  out  4  flags: EXACT=0001, INEXACT=0010, OVERFLOW=0100, UNDERFLOW=1000; held until next done

## Operation
- Encodings:
  - exponent 0 with mantissa 0 = zero (sign ignored on input);
  - exponent all-ones = saturated/overflow value;
  - any other exponent is normal.
  - No denormals.
- FSM: IDLE → ALIGN → OPERATE → NORMALIZE → ROUND → IDLE.
- IDLE: on start=1, latch A, B, op_sub; set busy. Otherwise hold.
- ALIGN:
  - Pick the larger exponent as the result exponent. Swap operands if needed.
  - Right-shift the smaller mantissa (hidden 1 + MAN_W bits, extended with 3 guard/round/sticky bits) by the exponent difference. Shifted-out bits OR into sticky.
  - If the difference > MAN_W+3, the small operand reduces to sticky only.
  - A zero operand contributes mantissa 0.
- OPERATE: effective sign equal → add magnitudes (one carry bit). Otherwise subtract smaller magnitude from larger; result sign = sign of larger. Equal magnitudes → +0, status EXACT.
- NORMALIZE: single cycle, no iteration.
  - Carry set → shift right 1 (sticky absorbs the LSB), exponent +1.
  - Otherwise → shift left by the leading-zero count from fpu_lzc, exponent − count.
  - If the exponent would drop below 1 → underflow path.
- ROUND: round-to-nearest-even on guard/round/sticky.
  - Increment when G and (R or S or LSB).
  - Mantissa carry-out → mantissa 0, exponent +1.
  - Any nonzero G/R/S → INEXACT.
- Result write, on the ROUND→IDLE edge: data_out, status_out, done=1, busy=0.
- Overflow: exponent ≥ 2^EXP_W−1, or either input has exponent all-ones. Output = {sign, all-ones, 0}; status OVERFLOW, ORed with INEXACT if rounding occurred.
- Underflow: output {sign, 0, 0}; status UNDERFLOW|INEXACT.
- EXACT only when no other flag is set. Flags otherwise combine by OR.

## Timing
- Start sampled at edge 0 → busy=1 after edge 0. Result and done update at edge 4 (latency 4 cycles). done is high for exactly one cycle.
- busy=0 after edge 4. The earliest next accept is edge 5; back-to-back throughput is one op per 5 cycles.
- start while busy: ignored, not queued. Operand changes after the accept edge: no effect.
- Reset (any state, including mid-op): at the sampling edge, state=IDLE, busy=0, done=0, data_out=0, status_out=0000. An aborted op never raises done.
- start and reset high together: reset wins.

## Structure
- Package fpu_pkg:
  - status_t enum (4-bit one-hot flag values);
  - state_t enum (IDLE, ALIGN, OPERATE, NORMALIZE, ROUND);
  - GRS width constant (3).
- Sub-module fpu_lzc:
  - parameter WIDTH;
  - combinational leading-zero count of the normalized-path mantissa;
  - output width $clog2(WIDTH+1).
- Top: fpu_addsub_param instantiates one fpu_lzc. Defaults reproduce the 32-bit 1/6/25 format.

## Test plan
- 0x40000000 + 0x40000000 (op_sub=0) → 0x42000000, status 0001. Done exactly 4 cycles after the start edge; busy high for those cycles.
- 0x40000000 with op_sub=1 on 0x40000000 → 0x00000000, status 0001. Repeat with 0x40000000 + 0xC0000000 → same result.
- Ties to even:
  - 0x40000000 + 0x0C000000 (exponent difference 26, exact half ULP) → 0x40000000, status 0010;
  - 0x40000001 + 0x0C000000 → 0x40000002, status 0010.
- 0x7C000000 + 0x7C000000 → 0x7E000000, status 0100. Then 0x02000001 − 0x02000000 → 0x00000000, status 1010.
- Start held high during busy plus operand changes mid-op → exactly one done, result of the latched operands.
- Reset asserted at cycle 2 of an op → next cycle busy=0, done=0, outputs 0, and no done follows. Non-default EXP_W=8/MAN_W=23 build passes the first scenario with the corresponding encodings.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared types and constants for the parametrised floating-point add/sub unit.
package fpu_pkg;

   // Guard, round and sticky bits carried below the mantissa LSB
   localparam int GRS_W = 3;

   // One-hot result flags; several may be ORed together on one result
   typedef enum logic [3:0] {
      ST_EXACT     = 4'b0001,
      ST_INEXACT   = 4'b0010,
      ST_OVERFLOW  = 4'b0100,
      ST_UNDERFLOW = 4'b1000
   } status_t;

   // Controller states; one operation walks through all of them in order
   typedef enum logic [2:0] {
      IDLE,
      ALIGN,
      OPERATE,
      NORMALIZE,
      ROUND
   } state_t;

endpackage

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter; an all-zero input returns WIDTH.
module fpu_lzc #(
   parameter int WIDTH = 29,
   localparam int CW = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] value,
   output logic [CW-1:0]    count
);

   // Scan upward so the highest set bit is the last one to write the count
   always_comb begin
      // NOTE: default before the loop so every path assigns count (no latch).
      count = CW'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (value[i]) count = CW'(WIDTH - 1 - i);
      end
   end

endmodule

// File: rtl/fpu_addsub_param.sv
// Handshaked floating-point adder/subtractor: sign | EXP_W exponent | MAN_W
// mantissa with hidden 1, fixed 4-cycle latency, round-to-nearest-even,
// saturating overflow and flush-to-zero underflow.
module fpu_addsub_param
   import fpu_pkg::*;
#(
   parameter int EXP_W = 6,
   parameter int MAN_W = 25,
   localparam int W = 1 + EXP_W + MAN_W
) (
   input  logic         clock100KHz,
   input  logic         reset,
   input  logic         start,
   input  logic         op_sub,
   input  logic [W-1:0] op_A_in,
   input  logic [W-1:0] op_B_in,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] data_out,
   output logic [3:0]   status_out
);

   localparam int M   = MAN_W + 1;          // mantissa with hidden bit
   localparam int EXT = M + GRS_W;          // mantissa plus guard/round/sticky
   localparam int CW  = $clog2(EXT + 1);
   // Signed working exponent, wide enough for +1 carries and -EXT shifts
   localparam int XW  = ((EXP_W > CW) ? EXP_W : CW) + 2;
   localparam logic signed [XW-1:0] EXP_MAX = XW'(2**EXP_W - 1);
   localparam logic signed [XW-1:0] EXP_MIN = XW'(1);

   state_t                 state;
   logic [W-1:0]           a_q, b_q;
   logic                   sub_q;
   logic [EXT-1:0]         big_q, small_q;
   logic [EXT:0]           sum_q;
   logic [EXT-2:0]         norm_q;
   logic signed [XW-1:0]   exp_q;
   logic                   sign_q, eff_sub_q, ovf_in_q, zero_q, unf_q;

   // Alignment signals
   logic [EXP_W-1:0] exp_a, exp_b, exp_big, exp_small, exp_diff;
   logic [M-1:0]     man_a, man_b, man_big, man_small;
   logic             sign_a, sign_b, sign_big, swap, lost;
   logic [EXT-1:0]   small_ext, aligned;

   // Order operands by magnitude and shift the smaller one into place
   always_comb begin
      exp_a  = a_q[W-2 -: EXP_W];
      exp_b  = b_q[W-2 -: EXP_W];
      man_a  = {(exp_a != '0) || (a_q[MAN_W-1:0] != '0), a_q[MAN_W-1:0]};
      man_b  = {(exp_b != '0) || (b_q[MAN_W-1:0] != '0), b_q[MAN_W-1:0]};
      sign_a = a_q[W-1];
      sign_b = b_q[W-1] ^ sub_q;
      // Keeping the larger magnitude on the "big" side means subtraction
      // never goes negative and the result sign is simply sign_big.
      swap      = {exp_b, man_b} > {exp_a, man_a};
      exp_big   = swap ? exp_b  : exp_a;
      exp_small = swap ? exp_a  : exp_b;
      man_big   = swap ? man_b  : man_a;
      man_small = swap ? man_a  : man_b;
      sign_big  = swap ? sign_b : sign_a;
      exp_diff  = exp_big - exp_small;
      small_ext = {man_small, {GRS_W{1'b0}}};
      // Shifts beyond EXT leave nothing but the sticky bit, which this
      // mask-based form already yields.
      lost      = |(small_ext & ~({EXT{1'b1}} << exp_diff));
      aligned   = (small_ext >> exp_diff) | EXT'(lost);
   end

   // Add or subtract aligned magnitudes with one carry bit
   logic [EXT:0] sum_d;
   always_comb begin
      if (eff_sub_q) sum_d = {1'b0, big_q} - {1'b0, small_q};
      else           sum_d = {1'b0, big_q} + {1'b0, small_q};
   end

   // Normalisation signals
   logic [CW-1:0]        lz_count;
   logic [EXT-2:0]       norm_d;
   logic signed [XW-1:0] exp_n;
   logic                 zero_d, unf_d;

   fpu_lzc #(.WIDTH(EXT)) u_lzc (
      .value (sum_q[EXT-1:0]),
      .count (lz_count)
   );

   // Single-step normalise; the hidden bit is dropped from the stored value
   always_comb begin
      if (sum_q[EXT]) begin
         norm_d = {sum_q[EXT-1:2], sum_q[1] | sum_q[0]};
         exp_n  = exp_q + XW'(1);
      end else begin
         norm_d = (EXT-1)'(sum_q[EXT-1:0] << lz_count);
         exp_n  = exp_q - XW'(lz_count);
      end
      zero_d = (sum_q == '0);
      unf_d  = !zero_d && (exp_n < EXP_MIN);
   end

   // Rounding and result packing
   logic [MAN_W-1:0]     man_r;
   logic                 man_carry, round_up, inexact;
   logic signed [XW-1:0] exp_r;
   logic [W-1:0]         result_d;
   logic [3:0]           status_d;

   // Round to nearest even, then pick saturated, flushed, zero or normal result
   always_comb begin
      round_up = norm_q[2] & (norm_q[1] | norm_q[0] | norm_q[3]);
      inexact  = |norm_q[2:0];
      {man_carry, man_r} = {1'b0, norm_q[EXT-2:GRS_W]} + (MAN_W+1)'(round_up);
      exp_r = exp_q + XW'(man_carry);
      if (ovf_in_q || (!zero_q && !unf_q && exp_r >= EXP_MAX)) begin
         result_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         status_d = ST_OVERFLOW | (inexact ? ST_INEXACT : 4'b0000);
      end else if (zero_q) begin
         result_d = '0;
         status_d = ST_EXACT;
      end else if (unf_q) begin
         result_d = {sign_q, {(W-1){1'b0}}};
         status_d = ST_UNDERFLOW | ST_INEXACT;
      end else begin
         result_d = {sign_q, exp_r[EXP_W-1:0], man_r};
         status_d = inexact ? ST_INEXACT : ST_EXACT;
      end
   end

   // Controller, pipeline state and registered handshake/result outputs
   always_ff @(posedge clock100KHz) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         data_out   <= '0;
         status_out <= '0;
         a_q        <= '0;
         b_q        <= '0;
         sub_q      <= 1'b0;
         big_q      <= '0;
         small_q    <= '0;
         sum_q      <= '0;
         norm_q     <= '0;
         exp_q      <= '0;
         sign_q     <= 1'b0;
         eff_sub_q  <= 1'b0;
         ovf_in_q   <= 1'b0;
         zero_q     <= 1'b0;
         unf_q      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_q   <= op_A_in;
                  b_q   <= op_B_in;
                  sub_q <= op_sub;
                  busy  <= 1'b1;
                  state <= ALIGN;
               end
            end
            ALIGN: begin
               big_q     <= {man_big, {GRS_W{1'b0}}};
               small_q   <= aligned;
               exp_q     <= XW'(exp_big);
               sign_q    <= sign_big;
               eff_sub_q <= sign_a ^ sign_b;
               ovf_in_q  <= (&exp_a) | (&exp_b);
               state     <= OPERATE;
            end
            OPERATE: begin
               sum_q <= sum_d;
               state <= NORMALIZE;
            end
            NORMALIZE: begin
               norm_q <= norm_d;
               exp_q  <= exp_n;
               zero_q <= zero_d;
               unf_q  <= unf_d;
               state  <= ROUND;
            end
            ROUND: begin
               data_out   <= result_d;
               status_out <= status_d;
               done       <= 1'b1;
               busy       <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_addsub_param.sv
// Self-checking bench for fpu_addsub_param: a table of directed vectors plus
// handshake, reset-abort and alternate-format sequences.
module tb_fpu_addsub_param;
   import fpu_pkg::*;

   logic        clk = 1'b0;
   logic        reset, start, start8, op_sub;
   logic [31:0] a_in, b_in;
   logic        busy, done, busy8, done8;
   logic [31:0] data_out, data8;
   logic [3:0]  status_out, status8;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   fpu_addsub_param dut (
      .clock100KHz (clk),
      .reset       (reset),
      .start       (start),
      .op_sub      (op_sub),
      .op_A_in     (a_in),
      .op_B_in     (b_in),
      .busy        (busy),
      .done        (done),
      .data_out    (data_out),
      .status_out  (status_out)
   );

   fpu_addsub_param #(.EXP_W(8), .MAN_W(23)) dut8 (
      .clock100KHz (clk),
      .reset       (reset),
      .start       (start8),
      .op_sub      (op_sub),
      .op_A_in     (a_in),
      .op_B_in     (b_in),
      .busy        (busy8),
      .done        (done8),
      .data_out    (data8),
      .status_out  (status8)
   );

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic [31:0] exp_data;
      logic [3:0]  exp_status;
   } vec_t;

   localparam int NV = 13;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Issue one operation on the default-format DUT and wait (bounded) for done
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        output logic [31:0] d, output logic [3:0] st, output int lat);
      @(negedge clk);
      a_in = a; b_in = b; op_sub = sub; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = c;
            break;
         end
      end
      d  = data_out;
      st = status_out;
   endtask

   initial begin
      logic [31:0] d;
      logic [3:0]  st;
      int          lat, n_done;

      vecs[0]  = '{"add_equal",    32'h40000000, 32'h40000000, 1'b0, 32'h42000000, ST_EXACT};
      vecs[1]  = '{"sub_equal",    32'h40000000, 32'h40000000, 1'b1, 32'h00000000, ST_EXACT};
      vecs[2]  = '{"add_opposite", 32'h40000000, 32'hC0000000, 1'b0, 32'h00000000, ST_EXACT};
      vecs[3]  = '{"tie_even",     32'h40000000, 32'h0C000000, 1'b0, 32'h40000000, ST_INEXACT};
      vecs[4]  = '{"tie_odd",      32'h40000001, 32'h0C000000, 1'b0, 32'h40000002, ST_INEXACT};
      vecs[5]  = '{"overflow",     32'h7C000000, 32'h7C000000, 1'b0, 32'h7E000000, ST_OVERFLOW};
      vecs[6]  = '{"underflow",    32'h02000001, 32'h02000000, 1'b1, 32'h00000000, 4'b1010};
      vecs[7]  = '{"zero_plus_x",  32'h00000000, 32'h40000000, 1'b0, 32'h40000000, ST_EXACT};
      vecs[8]  = '{"sticky_only",  32'h40000000, 32'h02000000, 1'b0, 32'h40000000, ST_INEXACT};
      vecs[9]  = '{"sub_renorm",   32'h42000000, 32'h40000000, 1'b1, 32'h40000000, ST_EXACT};
      vecs[10] = '{"neg_result",   32'h40000000, 32'h42000000, 1'b1, 32'hC0000000, ST_EXACT};
      vecs[11] = '{"round_carry",  32'h41FFFFFF, 32'h0C000000, 1'b0, 32'h42000000, ST_INEXACT};
      vecs[12] = '{"sat_input",    32'h7E000000, 32'h00000000, 1'b0, 32'h7E000000, ST_OVERFLOW};

      reset = 1'b1; start = 1'b0; start8 = 1'b0; op_sub = 1'b0;
      a_in = '0; b_in = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_data", data_out, 32'h0);
      check("reset_status", 32'(status_out), 32'h0);
      @(negedge clk);
      reset = 1'b0;

      // Cycle-exact handshake on the first scenario
      @(negedge clk);
      a_in = 32'h40000000; b_in = 32'h40000000; op_sub = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_after_accept", 32'(busy), 32'd1);
      for (int c = 1; c <= 3; c++) begin
         @(posedge clk); #1;
         check("busy_mid_op", 32'(busy), 32'd1);
         check("done_early", 32'(done), 32'd0);
      end
      @(posedge clk); #1;
      check("done_at_edge4", 32'(done), 32'd1);
      check("busy_at_edge4", 32'(busy), 32'd0);
      check("timing_data", data_out, 32'h42000000);
      check("timing_status", 32'(status_out), 32'(ST_EXACT));
      @(posedge clk); #1;
      check("done_one_cycle", 32'(done), 32'd0);
      check("data_held", data_out, 32'h42000000);

      // Table-driven vectors, issued back to back
      for (int i = 0; i < NV; i++) begin
         do_op(vecs[i].a, vecs[i].b, vecs[i].sub, d, st, lat);
         check({vecs[i].name, "_latency"}, 32'(lat), 32'd4);
         check({vecs[i].name, "_data"}, d, vecs[i].exp_data);
         check({vecs[i].name, "_status"}, 32'(st), 32'(vecs[i].exp_status));
      end

      // Start held high and operands changing while busy
      @(negedge clk);
      a_in = 32'h40000000; b_in = 32'h40000000; op_sub = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      n_done = 0;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         a_in = 32'h7C000000; b_in = 32'h7C000000; op_sub = 1'b1;
         @(posedge clk); #1;
         if (done) n_done++;
      end
      start = 1'b0;
      check("held_start_data", data_out, 32'h42000000);
      check("held_start_status", 32'(status_out), 32'(ST_EXACT));
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (done) n_done++;
      end
      check("held_start_one_done", 32'(n_done), 32'd1);

      // Reset in the middle of an operation aborts it silently
      @(negedge clk);
      a_in = 32'h7C000000; b_in = 32'h7C000000; op_sub = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_data", data_out, 32'h0);
      check("abort_status", 32'(status_out), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      n_done = 0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (done) n_done++;
      end
      check("abort_no_done", 32'(n_done), 32'd0);

      // Reset and start together: reset wins
      @(negedge clk);
      reset = 1'b1; start = 1'b1;
      a_in = 32'h40000000; b_in = 32'h40000000; op_sub = 1'b0;
      @(posedge clk); #1;
      check("reset_beats_start", 32'(busy), 32'd0);
      @(negedge clk);
      reset = 1'b0; start = 1'b0;

      // Alternate 8-bit exponent / 23-bit mantissa build
      @(negedge clk);
      a_in = 32'h40000000; b_in = 32'h40000000; op_sub = 1'b0; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      lat = 0;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk); #1;
         if (done8) begin
            lat = c;
            break;
         end
      end
      check("fmt8_latency", 32'(lat), 32'd4);
      check("fmt8_data", data8, 32'h40800000);
      check("fmt8_status", 32'(status8), 32'(ST_EXACT));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
